integer_neuron_activation_collect: RTL
======================================

# integer_neuron_activation_collect

Downstream stage of the integer vector dot-product unit. It takes one scalar dot-product result per neuron as it emerges (`in_valid`/`a`), adds a per-neuron bias, applies an arithmetic right shift and ReLU with saturation, and collects `NEURONS` results into a layer output vector. The vector is presented with a valid/ready handshake to the next layer's vector feeder.

## Interface
Parameters:
- `BITS`, 16, data width of inputs, biases and outputs (two's complement).
- `NEURONS`, 4, number of neurons per layer, which is the output vector length. Must be ≥ 1.
- `SHIFT`, 0, arithmetic right shift applied after bias add (requantisation), 0..BITS-1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `in_valid`  in  1  `a` carries a dot-product result this cycle.
- `a`  in  BITS  dot-product result, signed.
- `bias_wr`  in  1  write enable for the bias register file.
- `bias_addr`  in  $clog2(NEURONS)+1  neuron index for the bias write.
- `bias_data`  in  BITS  signed bias value.
- `out_ready`  in  1  consumer accepts `out_vector`.
- `out_valid`  out  1  `out_vector` is complete and stable.
- `out_vector`  out  BITS×NEURONS (unpacked array `[NEURONS]`)  activated results; element i belongs to neuron i.
- `drop_err`  out  1  sticky flag: an input was discarded because the buffer was full.

## Operation
- FSM states: `COLLECT` and `HOLD`.
- Index counter `idx` runs 0..NEURONS-1 and selects the neuron the next input belongs to.
- **COLLECT:**
  - On `in_valid`, compute `y = act(a + bias[idx])` and write it to `out_vector[idx]`.
  - If `idx == NEURONS-1`: set `idx ← 0` and go to `HOLD`. Otherwise `idx ← idx+1`.
- **HOLD:**
  - `out_valid = 1` and `out_vector` is frozen.
  - On `out_valid && out_ready`: go to `COLLECT`.
  - In that same cycle, if `in_valid` is also high, the input is accepted into slot 0 and `idx ← 1`. With NEURONS = 1, the state stays `HOLD` and slot 0 is rewritten.
  - `in_valid` in `HOLD` without `out_ready`: the input is dropped, nothing changes, and `drop_err ← 1`. It stays set until reset.
- **Activation `act`:**
  - Sign-extend `a` and the bias to BITS+1 bits and add them, so the sum cannot overflow.
  - Arithmetic right shift by SHIFT.
  - If the result is < 0, output 0 (ReLU).
  - If the result is > 2^(BITS-1)-1, output 2^(BITS-1)-1 (saturate).
  - Otherwise output the low BITS bits.
- **Bias file:**
  - `bias_wr` writes `bias[bias_addr] ← bias_data`.
  - Writes with `bias_addr ≥ NEURONS` are ignored.
  - A write and a use of the same slot in the same cycle: the use sees the old value.
- **Reset:**
  - `state = COLLECT`, `idx = 0`, `out_valid = 0`, every `out_vector` element = 0, every bias = 0, `drop_err = 0`.
  - Reset in the middle of a vector discards the partial vector.

## Timing
- Latency is 1 cycle: an input sampled at edge t is visible in `out_vector[idx]` after edge t.
- `out_valid` rises right after the edge that samples the last neuron.
- Handshake completes at the edge where `out_valid && out_ready`. `out_valid` is low the next cycle unless NEURONS = 1 and `in_valid` was high.
- Throughput: one input per cycle, with no lost cycle if `out_ready` is high in the same cycle the next vector's first input arrives.
- `out_ready` may be high while `out_valid` is low; it has no effect then.
- `out_vector` element values change only on an accepted input or on reset.

## Structure
- Shared package `integer_nn_pkg`:
  - `state_t` enum (`COLLECT`, `HOLD`).
  - Function `relu_sat(logic signed [BITS:0] x)` returning BITS bits, used by other layers.
- Sub-module `integer_bias_relu`:
  - Combinational bias add, shift and `relu_sat`.
  - Parameters BITS and SHIFT.
  - Instantiated once, muxed by `idx`.
- The top module holds the FSM, the `idx` counter, the bias file and the output buffer.

## Test plan
All scenarios use BITS=16, NEURONS=4, SHIFT=0 unless stated.
- Reset, then biases 0. Feed `a` = 5, -3, 32767, 0 on consecutive cycles → `out_valid` is high the cycle after the 4th input, `out_vector` = {5, 0, 32767, 0}, and with `out_ready=1` it clears after one cycle.
- Biases {10, 20, -5, 1}. Inputs {32767, -30, 3, -1} → {32767 (saturated), 0, 0, 0}.
- SHIFT=2, bias 0. Input 100 → 25; input -4 → 0; input 7 → 1.
- Hold `out_ready=0` after a full vector, then apply 2 extra inputs → vector unchanged, `drop_err=1`. Raise `out_ready` together with `in_valid`, `a=9` → next vector's slot 0 = 9 and `idx=1`.
- Assert `rst` after 2 of 4 inputs, then feed 4 inputs {1, 2, 3, 4} → `out_vector` = {1, 2, 3, 4}, and no earlier value appears.
- `bias_wr` with `bias_addr=5` and `bias_data=100`, then input 7 to each slot → all outputs 7 (the write was ignored).

Source files
------------

// File: rtl/integer_nn_pkg.sv
// Shared types and helpers for the integer neural-network datapath layers.
// relu_sat works on a fixed wide container so any BITS up to MAX_BITS can use it.
package integer_nn_pkg;

    localparam int unsigned MAX_BITS = 64;

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    // x is a sign-extended (BITS+1)-bit value; the result fits in the low `bits` bits
    function automatic logic [MAX_BITS-1:0] relu_sat(input logic signed [MAX_BITS:0] x,
                                                     input int unsigned bits);
        logic signed [MAX_BITS:0] max_pos;
        max_pos = (MAX_BITS+1)'(1) <<< (bits - 1);
        max_pos = max_pos - (MAX_BITS+1)'(1);
        if (x[MAX_BITS]) begin
            return '0;
        end
        if (x > max_pos) begin
            return max_pos[MAX_BITS-1:0];
        end
        return x[MAX_BITS-1:0];
    endfunction

endpackage

// File: rtl/integer_neuron_activation_collect_if.sv
// Bias-write, scalar-input and vector-output signals of the activation/collect stage.
interface integer_neuron_activation_collect_if #(
    parameter int unsigned BITS    = 16,
    parameter int unsigned NEURONS = 4
);
    localparam int unsigned ADDR_W = $clog2(NEURONS) + 1;

    logic              in_valid;
    logic [BITS-1:0]   a;
    logic              bias_wr;
    logic [ADDR_W-1:0] bias_addr;
    logic [BITS-1:0]   bias_data;
    logic              out_ready;
    logic              out_valid;
    logic [BITS-1:0]   out_vector [NEURONS];
    logic              drop_err;

    modport master (
        output in_valid, a, bias_wr, bias_addr, bias_data, out_ready,
        input  out_valid, out_vector, drop_err
    );

    modport slave (
        input  in_valid, a, bias_wr, bias_addr, bias_data, out_ready,
        output out_valid, out_vector, drop_err
    );

endinterface

// File: rtl/integer_bias_relu.sv
// Combinational bias add, arithmetic right shift and ReLU with saturation.
module integer_bias_relu
    import integer_nn_pkg::*;
#(
    parameter int unsigned BITS  = 16,
    parameter int unsigned SHIFT = 0
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_bias,
    output logic [BITS-1:0] o_y
);

    logic signed [BITS:0]     w_sum;
    logic signed [BITS:0]     w_shift;
    logic signed [MAX_BITS:0] w_wide;

    // One extra bit of headroom so the bias add can never wrap
    assign w_sum   = $signed({i_a[BITS-1], i_a}) + $signed({i_bias[BITS-1], i_bias});
    assign w_shift = w_sum >>> SHIFT;
    assign w_wide  = {{(MAX_BITS - BITS){w_shift[BITS]}}, w_shift};
    assign o_y     = BITS'(relu_sat(w_wide, BITS));

endmodule

// File: rtl/integer_neuron_activation_collect.sv
// Collects NEURONS activated dot-product results into a vector and hands it on with
// a valid/ready handshake; holds the bias file and flags inputs dropped while full.
module integer_neuron_activation_collect
    import integer_nn_pkg::*;
#(
    parameter int unsigned BITS    = 16,
    parameter int unsigned NEURONS = 4,
    parameter int unsigned SHIFT   = 0
) (
    input logic clk,
    input logic rst,
    integer_neuron_activation_collect_if.slave bus
);

    localparam int unsigned IDX_W  = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam int unsigned ADDR_W = $clog2(NEURONS) + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [BITS-1:0]  r_vec  [NEURONS];
    logic [BITS-1:0]  r_bias [NEURONS];
    logic             r_drop;
    logic             w_accept;
    logic             w_drop;
    logic             w_bias_we;
    logic [BITS-1:0]  w_y;

    // In HOLD an input is only taken in the cycle the held vector is consumed
    assign w_accept  = bus.in_valid && ((r_state == COLLECT) || bus.out_ready);
    assign w_drop    = bus.in_valid && (r_state == HOLD) && !bus.out_ready;
    assign w_bias_we = bus.bias_wr && (bus.bias_addr < ADDR_W'(NEURONS));

    integer_bias_relu #(
        .BITS  (BITS),
        .SHIFT (SHIFT)
    ) u_bias_relu (
        .i_a    (bus.a),
        .i_bias (r_bias[r_idx]),
        .o_y    (w_y)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if ((r_state == HOLD) && bus.out_ready) begin
            w_state_nxt = COLLECT;
        end
        // idx is 0 whenever HOLD accepts, so the COLLECT rule covers both states
        if (w_accept) begin
            if (r_idx == IDX_W'(NEURONS - 1)) begin
                w_idx_nxt   = '0;
                w_state_nxt = HOLD;
            end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
            r_idx   <= '0;
            r_drop  <= 1'b0;
            for (int i = 0; i < int'(NEURONS); i++) begin
                r_vec[i]  <= '0;
                r_bias[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_accept) begin
                r_vec[r_idx] <= w_y;
            end
            if (w_bias_we) begin
                r_bias[bus.bias_addr[IDX_W-1:0]] <= bus.bias_data;
            end
            if (w_drop) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign bus.out_valid = (r_state == HOLD);
    assign bus.drop_err  = r_drop;

    always_comb begin
        for (int i = 0; i < int'(NEURONS); i++) begin
            bus.out_vector[i] = r_vec[i];
        end
    end

endmodule
